// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I opcode types, funct3 codes, NOP word and encoder FSM states
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        LOADTYPE   = 5'b00000,
        OPIMM      = 5'b00100,
        AUIPC      = 5'b00101,
        SAVETYPE   = 5'b01000,
        OP         = 5'b01100,
        LUI        = 5'b01101,
        BRANCHTYPE = 5'b11000,
        JALR       = 5'b11001,
        JAL        = 5'b11011
    } op_type_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when v is representable as a two's-complement value of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - structured-instruction beat stream into the encoder
interface instr_encoder_if;
    logic        Valid_i;
    logic        Ready_o;
    logic        Last_i;
    logic [4:0]  Type_i;
    logic [2:0]  Function3_i;
    logic        Alt_i;
    logic [4:0]  Rd_i;
    logic [4:0]  Rs1_i;
    logic [4:0]  Rs2_i;
    logic [31:0] Imm_i;

    modport master (
        output Valid_i, Last_i, Type_i, Function3_i, Alt_i, Rd_i, Rs1_i, Rs2_i, Imm_i,
        input  Ready_o
    );

    modport slave (
        input  Valid_i, Last_i, Type_i, Function3_i, Alt_i, Rd_i, Rs1_i, Rs2_i, Imm_i,
        output Ready_o
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational RV32I field packer; INSTR_ENC_IMM_CHECK_EN adds immediate range checks
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  type_sel,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);
    logic [6:0]  opc;
    logic [31:0] enc;
    logic        bad_enc;
    logic        is_shift;

    assign opc      = {type_sel, 2'b11};
    assign is_shift = (type_sel == OPIMM) && ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));

    always_comb begin
        enc     = NOP_WORD;
        bad_enc = 1'b0;
        case (type_sel)
            LUI, AUIPC: enc = {imm[31:12], rd, opc};
            JAL:        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            JALR, LOADTYPE: enc = {imm[11:0], rs1, funct3, rd, opc};
            SAVETYPE:   enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc};
            BRANCHTYPE: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc};
            OPIMM: begin
                if (is_shift) begin
                    enc     = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, opc};
                    bad_enc = alt && (funct3 != F3_SRL_SRA);
                end else begin
                    enc     = {imm[11:0], rs1, funct3, rd, opc};
                    bad_enc = alt;
                end
            end
            OP: begin
                enc     = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, opc};
                bad_enc = alt && (funct3 != F3_ADD_SUB) && (funct3 != F3_SRL_SRA);
            end
            default: bad_enc = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_IMM_CHECK_EN
    logic bad_imm;

    always_comb begin
        bad_imm = 1'b0;
        case (type_sel)
            LUI, AUIPC:               bad_imm = (imm[11:0] != 12'h000);
            JAL:                      bad_imm = !fits_signed(imm, 21) || imm[0];
            BRANCHTYPE:               bad_imm = !fits_signed(imm, 13) || imm[0];
            SAVETYPE, LOADTYPE, JALR: bad_imm = !fits_signed(imm, 12);
            OPIMM:                    bad_imm = is_shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
            default:                  bad_imm = 1'b0;
        endcase
    end

    assign err = bad_enc || bad_imm;
`else
    assign err = bad_enc;
`endif

    assign word = err ? NOP_WORD : enc;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - session FSM, IMEM write pointer/counter and registered write port
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              Start_i,
    instr_encoder_if.slave    beat,
    output logic              ImemWe_o,
    output logic [ADDR_W-1:0] ImemAddr_o,
    output logic [31:0]       ImemWdata_o,
    output logic [ADDR_W:0]   Count_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              Err_o
);
    localparam logic [ADDR_W:0]   DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_COUNT = DEPTH - 1'b1;
    localparam logic [ADDR_W-1:0] BASE       = BASE_ADDR[ADDR_W-1:0];

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              start_session;
    logic [31:0]       pack_word;
    logic              pack_err;

    instr_pack u_pack (
        .type_sel (beat.Type_i),
        .funct3   (beat.Function3_i),
        .alt      (beat.Alt_i),
        .rd       (beat.Rd_i),
        .rs1      (beat.Rs1_i),
        .rs2      (beat.Rs2_i),
        .imm      (beat.Imm_i),
        .word     (pack_word),
        .err      (pack_err)
    );

    assign accept        = beat.Valid_i && beat.Ready_o;
    assign start_session = Start_i && (state != ST_RUN);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (Start_i) state_nxt = ST_RUN;
            ST_RUN: if (accept && (beat.Last_i || (Count_o == LAST_COUNT))) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy_o       = (state == ST_RUN);
        Done_o       = (state == ST_DONE);
        beat.Ready_o = (state == ST_RUN) && (Count_o < DEPTH);
    end

    // Ready_o drops at DEPTH, so Count_o can never step past it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ImemWe_o    <= 1'b0;
            ImemAddr_o  <= BASE;
            ImemWdata_o <= '0;
            Count_o     <= '0;
            Err_o       <= 1'b0;
            ptr         <= BASE;
        end else begin
            ImemWe_o <= accept;
            if (start_session) begin
                ptr     <= BASE;
                Count_o <= '0;
                Err_o   <= 1'b0;
            end else if (accept) begin
                ImemAddr_o  <= ptr;
                ImemWdata_o <= pack_word;
                ptr         <= ptr + 1'b1;
                Count_o     <= Count_o + 1'b1;
                Err_o       <= Err_o || pack_err;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized bench for instr_encoder with a behavioural reference model
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   count;
    logic              busy, done, err;

    instr_encoder_if bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .Start_i     (start),
        .beat        (bus),
        .ImemWe_o    (we),
        .ImemAddr_o  (addr),
        .ImemWdata_o (wdata),
        .Count_o     (count),
        .Busy_o      (busy),
        .Done_o      (done),
        .Err_o       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state: 0 idle, 1 run, 2 done
    int          m_state, m_count, m_ptr;
    bit          m_err, m_we;
    logic [31:0] m_addr, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_encode(input logic [4:0] ty, input logic [2:0] f3, input logic alt,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] op, d, s1, s2, f, a, w;
        int si;
        bit bad, range_bad, shift;
        op = 32'(ty) * 4 + 3;
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        f  = 32'(f3) << 12;
        a  = 32'(alt) << 30;
        si = $signed(imm);
        bad = 0;
        range_bad = 0;
        shift = (ty == OPIMM) && (f3 == 1 || f3 == 5);
        if (ty == LUI || ty == AUIPC) begin
            w = (imm & 32'hFFFFF000) | d | op;
            range_bad = (imm % 4096) != 0;
        end else if (ty == JAL) begin
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                | (imm & 32'h000FF000) | d | op;
            range_bad = si < -1048576 || si > 1048574 || (imm % 2) != 0;
        end else if (ty == BRANCHTYPE) begin
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | s2 | s1 | f
                | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
            range_bad = si < -4096 || si > 4094 || (imm % 2) != 0;
        end else if (ty == SAVETYPE) begin
            w = (((imm >> 5) & 127) << 25) | s2 | s1 | f | ((imm & 31) << 7) | op;
            range_bad = si < -2048 || si > 2047;
        end else if (shift) begin
            w = a | ((imm & 31) << 20) | s1 | f | d | op;
            bad = alt && f3 != 5;
            range_bad = imm >= 32;
        end else if (ty == JALR || ty == LOADTYPE || ty == OPIMM) begin
            w = ((imm & 32'hFFF) << 20) | s1 | f | d | op;
            bad = (ty == OPIMM) && alt;
            range_bad = si < -2048 || si > 2047;
        end else if (ty == OP) begin
            w = a | s2 | s1 | f | d | op;
            bad = alt && f3 != 0 && f3 != 5;
        end else begin
            w = 0;
            bad = 1;
        end
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = bad || range_bad;
`endif
        if (bad) w = 32'h13;
        return {bad, w};
    endfunction

    // Entered just after a negedge with inputs set; leaves at the next negedge after checking outputs.
    task automatic cycle();
        logic [32:0] r;
        bit rdy, acc;
        rdy = (m_state == 1) && (m_count < DEPTH);
        acc = rdy && bus.Valid_i && rst_n;
        chk("ready", 32'(bus.Ready_o), 32'(rdy));
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_ptr = BASE_ADDR; m_err = 0;
            m_we = 0; m_addr = BASE_ADDR; m_data = 0;
        end else begin
            m_we = acc;
            if (m_state != 1 && start) begin
                m_state = 1; m_count = 0; m_ptr = BASE_ADDR; m_err = 0;
            end else if (acc) begin
                r = ref_encode(bus.Type_i, bus.Function3_i, bus.Alt_i, bus.Rd_i, bus.Rs1_i, bus.Rs2_i, bus.Imm_i);
                m_addr  = m_ptr;
                m_data  = r[31:0];
                m_err   = m_err | r[32];
                m_ptr   = (m_ptr + 1) % DEPTH;
                m_count = m_count + 1;
                if (bus.Last_i || m_count == DEPTH) m_state = 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("we", 32'(we), 32'(m_we));
        chk("addr", 32'(addr), m_addr);
        chk("wdata", wdata, m_data);
        chk("count", 32'(count), 32'(m_count));
        chk("err", 32'(err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 2));
    endtask

    task automatic set_beat(input logic [4:0] ty, input logic [2:0] f3, input logic alt, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        bus.Valid_i = 1'b1; bus.Type_i = ty; bus.Function3_i = f3; bus.Alt_i = alt;
        bus.Rd_i = rd; bus.Rs1_i = rs1; bus.Rs2_i = rs2; bus.Imm_i = imm; bus.Last_i = last;
    endtask

    task automatic beat(input logic [4:0] ty, input logic [2:0] f3, input logic alt, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        set_beat(ty, f3, alt, rd, rs1, rs2, imm, last);
        cycle();
    endtask

    task automatic idle();
        bus.Valid_i = 1'b0; start = 1'b0;
        cycle();
    endtask

    task automatic go();
        bus.Valid_i = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic rand_beat(input logic last);
        logic [4:0]  ty;
        logic [2:0]  f3;
        logic [31:0] imm;
        int k;
        k  = $urandom_range(0, 9);
        f3 = 3'($urandom_range(0, 7));
        case (k)
            0: begin ty = LUI;        imm = $urandom() & 32'hFFFFF000; end
            1: begin ty = AUIPC;      imm = $urandom() & 32'hFFFFF000; end
            2: begin ty = JAL;        imm = (32'($urandom_range(0, 1048575)) << 1) - 32'd1048576; end
            3: begin ty = JALR;       imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            4: begin ty = BRANCHTYPE; imm = (32'($urandom_range(0, 4095)) << 1) - 32'd4096; end
            5: begin ty = LOADTYPE;   imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            6: begin ty = SAVETYPE;   imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            7: begin
                ty  = OPIMM;
                imm = (f3 == 1 || f3 == 5) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 4095)) - 32'd2048;
            end
            8: begin ty = OP;         imm = $urandom(); end
            default: begin ty = 5'b00011; imm = $urandom(); end
        endcase
        start = ($urandom_range(0, 7) == 0);
        beat(ty, f3, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), imm, last);
        start = 1'b0;
    endtask

    initial begin
        bus.Valid_i = 1'b0; bus.Last_i = 1'b0; bus.Type_i = '0; bus.Function3_i = '0; bus.Alt_i = 1'b0;
        bus.Rd_i = '0; bus.Rs1_i = '0; bus.Rs2_i = '0; bus.Imm_i = '0;
        m_state = 0; m_count = 0; m_ptr = BASE_ADDR; m_err = 0; m_we = 0; m_addr = BASE_ADDR; m_data = 0;
        repeat (2) @(negedge clk);
        cycle();
        rst_n = 1'b1;

        set_beat(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        cycle();
        chk("idle_ready", 32'(bus.Ready_o), 32'd0);

        go();
        beat(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        chk("addi_data", wdata, 32'h00500093);
        chk("addi_addr", 32'(addr), 32'(BASE_ADDR));
        idle();

        go();
        beat(OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add_data", wdata, 32'h002081B3);
        beat(OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("sub_data", wdata, 32'h402081B3);
        beat(LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        chk("lui_data", wdata, 32'h123452B7);
        chk("lui_addr", 32'(addr), 32'(BASE_ADDR + 2));
        idle();

        go();
        beat(JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        chk("jal_data", wdata, 32'h008000EF);
        beat(BRANCHTYPE, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16, 1'b0);
        chk("beq_data", wdata, 32'h00208863);
        beat(SAVETYPE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 1'b1);
        chk("sw_data", wdata, 32'h0020A223);
        idle();

        go();
        beat(5'b11111, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
        chk("badtype_data", wdata, 32'h00000013);
        chk("badtype_err", 32'(err), 32'd1);
        idle();

        go();
        beat(OPIMM, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b1);
        chk("bigimm_data", wdata, 32'h00000013);
`ifdef INSTR_ENC_IMM_CHECK_EN
        chk("bigimm_err", 32'(err), 32'd1);
`else
        chk("bigimm_err", 32'(err), 32'd0);
`endif
        idle();

        go();
        for (int i = 0; i < 5; i++) begin
            set_beat(OPIMM, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
            cycle();
        end
        chk("full_ready", 32'(bus.Ready_o), 32'd0);
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        idle();

        go();
        beat(OPIMM, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd7, 1'b0);
        set_beat(OPIMM, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8, 1'b0);
        rst_n = 1'b0;
        cycle();
        chk("rst_we", 32'(we), 32'd0);
        rst_n = 1'b1;
        idle();

        for (int s = 0; s < 40; s++) begin
            go();
            for (int b = 0, n = $urandom_range(1, 6); b < n; b++) begin
                if ($urandom_range(0, 3) == 0) idle();
                rand_beat((b == n - 1) && ($urandom_range(0, 1) == 1));
            end
            idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
